// File: rtl/apb_master_slave.sv
// Purpose : APB master FSM driving an internal zero-wait APB slave backed by a word-addressed register memory.
// Latency : request seen in IDLE -> SETUP -> ACCESS (ready=1) -> commit on the following edge (3 edges + WAIT_STATES).
// Backpressure: the slave holds pready low for WAIT_STATES extra ACCESS cycles; holding transfer=1 chains transfers with no IDLE.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-low reset
//   wr_en       in   1   1 = write, 0 = read (sampled entering SETUP)
//   transfer    in   1   request; 1 = start/continue transfers
//   address     in   32  word address; only the low log2(MEM_DEPTH) bits index memory
//   write_data  in   32  write data (sampled entering SETUP)
//   read_data   out  32  data of the last completed read (registered)
//   ready       out  1   high in the final ACCESS cycle of each transfer
module apb_master_slave #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        transfer,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_psel;
    logic           r_penable;
    logic           r_pwrite;
    logic [31:0]    r_paddr;
    logic [31:0]    r_pwdata;
    logic [2:0]     r_wait_cnt;
    logic [31:0]    r_read_data;
    logic [31:0]    r_mem [MEM_DEPTH];

    logic           w_pready;
    logic           w_ready;
    logic [AW-1:0]  w_idx;
    logic           w_unused_paddr_hi;

    // Slave side: ready once the wait counter has drained in ACCESS.
    assign w_pready = (r_state == ST_ACCESS) && (r_wait_cnt == 3'd0);
    assign w_ready  = r_psel & r_penable & w_pready;

    // Upper address bits alias onto the same words; no error response.
    assign w_idx             = r_paddr[AW-1:0];
    assign w_unused_paddr_hi = ^r_paddr[31:AW];

    assign read_data = r_read_data;
    assign ready     = w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_wait_cnt  <= '0;
            r_read_data <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (transfer) begin
                        r_state  <= ST_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= address;
                        r_pwdata <= write_data;
                        r_pwrite <= wr_en;
                    end
                end

                ST_SETUP: begin
                    r_state    <= ST_ACCESS;
                    r_psel     <= 1'b1;
                    r_penable  <= 1'b1;
                    r_wait_cnt <= 3'(WAIT_STATES);
                end

                ST_ACCESS: begin
                    if (w_pready) begin
                        // Commit happens on this edge, so a read in the next
                        // transfer already sees the new word.
                        if (r_pwrite) begin
                            r_mem[w_idx] <= r_pwdata;
                        end else begin
                            r_read_data <= r_mem[w_idx];
                        end
                        if (transfer) begin
                            r_state   <= ST_SETUP;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_paddr   <= address;
                            r_pwdata  <= write_data;
                            r_pwrite  <= wr_en;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_slave.sv
// Purpose : self-checking bench for apb_master_slave: directed scenarios plus randomized transfers.
// Latency : checks every cycle against a transfer-level reference model.
// Backpressure: none; the bench follows the DUT ready pulse with bounded waits.
module tb_apb_master_slave;

    localparam int DEPTH = 64;
    localparam int WS    = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        transfer;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    apb_master_slave #(
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .transfer   (transfer),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Reference model: a transfer occupies 2+WS cycles from the edge it is
    // accepted; ready is expected in its last cycle, effects land on the
    // edge that ends it.
    int          m_phase;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rd;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_rd    = 32'd0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        end else begin
            bit start;
            start = 1'b0;
            if (m_phase == 0) begin
                start = transfer;
            end else if (m_phase == 2 + WS) begin
                if (m_wr) m_mem[m_addr % DEPTH] = m_data;
                else      m_rd = m_mem[m_addr % DEPTH];
                start   = transfer;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
            if (start) begin
                m_phase = 1;
                m_wr    = wr_en;
                m_addr  = address;
                m_data  = write_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {31'd0, ready}, {31'd0, (m_phase == 2 + WS)});
            chk("cyc_read_data", read_data, m_rd);
        end
    end

    // Called at a negedge; leaves transfer=1 at the negedge of the ready cycle.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, output int lat);
        transfer   = 1'b1;
        wr_en      = wr;
        address    = a;
        write_data = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready && scramble) begin
                address    = $urandom;
                write_data = $urandom;
                wr_en      = $urandom_range(0, 1);
            end
        end while (!ready && lat < 20);
        if (!ready) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        transfer = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        int l;
        xfer(1'b0, a, 32'd0, 1'b0, l);
        idle(1);
        v = read_data;
    endtask

    initial begin
        int          lat;
        logic [31:0] v;
        rst = 1'b1; transfer = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        #3 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        rd(32'd40, v);
        chk("reset_mem_read", v, 32'd0);

        // Single write then immediate read-back.
        xfer(1'b1, 32'd23, 32'd47, 1'b0, lat);
        chk("write_latency", lat, 32'd2);
        xfer(1'b0, 32'd23, 32'd0, 1'b0, lat);
        chk("b2b_read_latency", lat, 32'd2);
        idle(1);
        chk("readback_23", read_data, 32'd47);

        // Back-to-back writes, no IDLE in between.
        xfer(1'b1, 32'd1, 32'd5, 1'b0, lat);
        xfer(1'b1, 32'd2, 32'd9, 1'b0, lat);
        chk("b2b_write_latency", lat, 32'd2);
        idle(1);
        chk("write_keeps_read_data", read_data, 32'd47);
        rd(32'd1, v); chk("readback_1", v, 32'd5);
        rd(32'd2, v); chk("readback_2", v, 32'd9);

        // Address wrap.
        xfer(1'b1, 32'd87, 32'hDEADBEEF, 1'b0, lat);
        idle(1);
        rd(32'd23, v); chk("wrap_87_23", v, 32'hDEADBEEF);
        xfer(1'b1, 32'hFFFF_FFC5, 32'h0BADF00D, 1'b0, lat);
        idle(1);
        rd(32'd5, v); chk("wrap_hi_bits", v, 32'h0BADF00D);

        // Inputs changed during SETUP and ACCESS do not affect the transfer.
        transfer = 1'b1; wr_en = 1'b1; address = 32'd10; write_data = 32'h1234;
        @(negedge clk);
        address = 32'd11; write_data = 32'h5678;
        @(negedge clk);
        chk("hold_ready", {31'd0, ready}, 32'd1);
        address = 32'd12; wr_en = 1'b0; transfer = 1'b0;
        @(negedge clk);
        rd(32'd10, v); chk("hold_addr10", v, 32'h1234);
        rd(32'd11, v); chk("hold_addr11", v, 32'd0);

        // Async reset in the middle of ACCESS.
        transfer = 1'b1; wr_en = 1'b1; address = 32'd3; write_data = 32'h55;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_read_data", read_data, 32'd0);
        transfer = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(32'd3, v); chk("rst_abort_addr3", v, 32'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 300; it++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            xfer(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), lat);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
